// File: rtl/dmem_responder.sv
// LEGv8 data-memory responder: one-cycle writes, wait-stated reads, stall to hazard unit.
// Optional array dump sequencer enabled by defining DMEM_DUMP_EN.
module dmem_responder #(
    parameter int N    = 64,
    parameter int AW   = 6,
    parameter int WAIT = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          memRead,
    input  logic          memWrite,
    input  logic [AW-1:0] address,
    input  logic [N-1:0]  writeData,
    output logic [N-1:0]  readData,
    output logic          rvalid,
    output logic          stall,
    input  logic          dump,
    output logic          dump_valid,
    output logic [AW-1:0] dump_addr,
    output logic [N-1:0]  dump_data
);

    localparam int DEPTH = 1 << AW;

`ifdef DMEM_DUMP_EN
    typedef enum logic [1:0] {IDLE, RWAIT, DUMP} state_t;
`else
    typedef enum logic [1:0] {IDLE, RWAIT} state_t;
`endif

    state_t        state, state_nx;
    logic [2:0]    cnt, cnt_nx;
    logic [AW-1:0] raddr;
    logic [N-1:0]  rdata_q;
    logic [N-1:0]  mem [DEPTH];
    logic          stall_c;
    logic          wr_en;
    logic          lat;
    logic          ld;
    logic [AW-1:0] ld_addr;
    logic          dump_go;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            raddr   <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (lat)
                raddr <= address;
            if (ld)
                rdata_q <= mem[ld_addr];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (wr_en) begin
            mem[address] <= writeData;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        stall_c  = 1'b0;
        wr_en    = 1'b0;
        lat      = 1'b0;
        unique case (state)
            IDLE: begin
                if (memWrite) begin
                    wr_en = 1'b1;
                end else if (memRead) begin
                    stall_c = 1'b1;
                    if (!dump_go) begin
                        lat      = 1'b1;
                        cnt_nx   = 3'(WAIT - 1);
                        state_nx = RWAIT;
                    end
                end
`ifdef DMEM_DUMP_EN
                if (dump_go)
                    state_nx = DUMP;
`endif
            end
            RWAIT: begin
                if (cnt != 3'd0) begin
                    stall_c = 1'b1;
                    cnt_nx  = cnt - 3'd1;
                end else begin
                    state_nx = IDLE;
                end
            end
`ifdef DMEM_DUMP_EN
            DUMP: begin
                stall_c = 1'b1;
                if (dump_addr == AW'(DEPTH - 1))
                    state_nx = IDLE;
            end
`endif
            default: state_nx = IDLE;
        endcase
    end

    // Load the result one edge early so readData is a plain register
    assign ld      = (lat && (WAIT == 1)) || (state == RWAIT && cnt == 3'd1);
    assign ld_addr = lat ? address : raddr;

    assign readData = rdata_q;
    assign rvalid   = (state == RWAIT) && (cnt == 3'd0);
    assign stall    = stall_c & ~reset;

`ifdef DMEM_DUMP_EN
    logic          dump_q;
    logic          pend;
    logic [AW-1:0] k;
    logic          dump_rise;

    assign dump_rise = dump & ~dump_q;
    assign dump_go   = (state == IDLE) && (dump_rise || pend);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dump_q <= 1'b0;
            pend   <= 1'b0;
            k      <= '0;
        end else begin
            dump_q <= dump;
            if (state == IDLE)
                pend <= 1'b0;
            else if (dump_rise)
                pend <= 1'b1;
            if (state == DUMP)
                k <= k + 1'b1;
        end
    end

    assign dump_valid = (state == DUMP);
    assign dump_addr  = dump_valid ? k : '0;
    assign dump_data  = dump_valid ? mem[k] : '0;
`else
    logic unused_dump;

    assign unused_dump = dump;
    assign dump_go     = 1'b0;
    assign dump_valid  = 1'b0;
    assign dump_addr   = '0;
    assign dump_data   = '0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (WAIT=2); dump checks follow DMEM_DUMP_EN.
module tb_dmem_responder;

    localparam int N    = 64;
    localparam int AW   = 6;
    localparam int WAIT = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          memRead;
    logic          memWrite;
    logic [AW-1:0] address;
    logic [N-1:0]  writeData;
    logic [N-1:0]  readData;
    logic          rvalid;
    logic          stall;
    logic          dump;
    logic          dump_valid;
    logic [AW-1:0] dump_addr;
    logic [N-1:0]  dump_data;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    dmem_responder #(.N(N), .AW(AW), .WAIT(WAIT)) dut (
        .clk        (clk),
        .reset      (reset),
        .memRead    (memRead),
        .memWrite   (memWrite),
        .address    (address),
        .writeData  (writeData),
        .readData   (readData),
        .rvalid     (rvalid),
        .stall      (stall),
        .dump       (dump),
        .dump_valid (dump_valid),
        .dump_addr  (dump_addr),
        .dump_data  (dump_data)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic probe();
        @(negedge clk);
    endtask

    // Issue a read at the start of a cycle and check the full wait sequence
    task automatic do_read(input string tag, input logic [AW-1:0] a,
                           input logic [N-1:0] exp);
        next();
        memRead  = 1'b1;
        memWrite = 1'b0;
        address  = a;
        for (int i = 0; i < WAIT; i++) begin
            if (i > 0)
                next();
            probe();
            check({tag, "_stall"}, 64'(stall), 64'd1);
            check({tag, "_novalid"}, 64'(rvalid), 64'd0);
        end
        next();
        memRead = 1'b0;
        probe();
        check({tag, "_rvalid"}, 64'(rvalid), 64'd1);
        check({tag, "_nostall"}, 64'(stall), 64'd0);
        check({tag, "_data"}, readData, exp);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [N-1:0] d);
        next();
        memRead   = 1'b0;
        memWrite  = 1'b1;
        address   = a;
        writeData = d;
    endtask

    initial begin
        reset     = 1'b1;
        memRead   = 1'b0;
        memWrite  = 1'b0;
        address   = '0;
        writeData = '0;
        dump      = 1'b0;
        repeat (2) @(posedge clk);
        probe();
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_rvalid", 64'(rvalid), 64'd0);
        check("rst_rdata", readData, 64'd0);
        check("rst_dvalid", 64'(dump_valid), 64'd0);
        check("rst_daddr", 64'(dump_addr), 64'd0);
        check("rst_ddata", dump_data, 64'd0);
        next();
        reset = 1'b0;

        do_read("rd5", 6'd5, 64'd0);

        do_write(6'd63, 64'hDEADBEEF_CAFEF00D);
        probe();
        check("wr63_stall", 64'(stall), 64'd0);
        do_read("rd63", 6'd63, 64'hDEADBEEF_CAFEF00D);

        do_write(6'd63, 64'h55);
        probe();
        next();
        memWrite = 1'b0;
        probe();
        check("rdata_hold", readData, 64'hDEADBEEF_CAFEF00D);
        check("hold_novalid", 64'(rvalid), 64'd0);

        next();
        memRead   = 1'b1;
        memWrite  = 1'b1;
        address   = 6'd3;
        writeData = 64'h11;
        probe();
        check("rw_stall", 64'(stall), 64'd0);
        next();
        memRead  = 1'b0;
        memWrite = 1'b0;
        probe();
        check("rw_norvalid", 64'(rvalid), 64'd0);
        check("rw_nostall", 64'(stall), 64'd0);
        do_read("rd3", 6'd3, 64'h11);

        do_write(6'd7, 64'h77);
        next();
        memWrite = 1'b0;
        memRead  = 1'b1;
        address  = 6'd7;
        probe();
        check("r7_stall0", 64'(stall), 64'd1);
        next();
        #1;
        reset = 1'b1;
        #1;
        check("arst_stall", 64'(stall), 64'd0);
        check("arst_rvalid", 64'(rvalid), 64'd0);
        check("arst_rdata", readData, 64'd0);
        next();
        reset   = 1'b0;
        memRead = 1'b0;
        do_read("rd7_clr", 6'd7, 64'd0);
        do_read("rd63_clr", 6'd63, 64'd0);

`ifdef DMEM_DUMP_EN
        for (int k = 0; k < 64; k++)
            do_write(AW'(k), 64'(k + 100));
        next();
        memWrite = 1'b0;
        dump     = 1'b1;
        probe();
        check("dump_edge_dv", 64'(dump_valid), 64'd0);
        for (int i = 0; i < 64; i++) begin
            next();
            probe();
            check("dump_valid", 64'(dump_valid), 64'd1);
            check("dump_addr", 64'(dump_addr), 64'(i));
            check("dump_data", dump_data, 64'(i + 100));
            check("dump_stall", 64'(stall), 64'd1);
        end
        for (int i = 0; i < 3; i++) begin
            next();
            probe();
            check("dump_noretrig", 64'(dump_valid), 64'd0);
            check("dump_end_stall", 64'(stall), 64'd0);
        end
        next();
        dump = 1'b0;
        next();
        memRead = 1'b1;
        address = 6'd1;
        next();
        dump = 1'b1;
        probe();
        check("pend_stall", 64'(stall), 64'd1);
        next();
        memRead = 1'b0;
        probe();
        check("pend_rvalid", 64'(rvalid), 64'd1);
        check("pend_rdata", readData, 64'd101);
        check("pend_rw_dv", 64'(dump_valid), 64'd0);
        next();
        probe();
        check("pend_idle_dv", 64'(dump_valid), 64'd0);
        next();
        probe();
        check("pend_dv0", 64'(dump_valid), 64'd1);
        check("pend_da0", 64'(dump_addr), 64'd0);
        check("pend_dd0", dump_data, 64'd100);
        repeat (64) next();
        probe();
        check("pend_done_dv", 64'(dump_valid), 64'd0);
        check("pend_done_stall", 64'(stall), 64'd0);
        dump = 1'b0;
`else
        next();
        dump = 1'b1;
        for (int i = 0; i < 4; i++) begin
            probe();
            check("nodump_dv", 64'(dump_valid), 64'd0);
            check("nodump_stall", 64'(stall), 64'd0);
            check("nodump_data", dump_data, 64'd0);
            next();
            dump = 1'b0;
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
